// File: rtl/dense_argmax_classifier_if.sv
// dense_argmax_classifier_if: score-buffer read port plus class result handshake.
// ARGMAX_SCORE_OUT_EN adds the class_score signal.
interface dense_argmax_classifier_if #(
  parameter int DATA_SIZE     = 32,
  parameter int OUT_ADR_WIDTH = 4
);
  logic                     start;
  logic                     busy;
  logic                     buf_rd;
  logic [OUT_ADR_WIDTH-1:0] buf_adr;
  logic [DATA_SIZE-1:0]     buf_data;
  logic [OUT_ADR_WIDTH-1:0] class_idx;
  logic                     class_valid;
  logic                     class_ready;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [DATA_SIZE-1:0]     class_score;
  modport master (output start, buf_data, class_ready,
                  input busy, buf_rd, buf_adr, class_idx, class_valid, class_score);
  modport slave  (input start, buf_data, class_ready,
                  output busy, buf_rd, buf_adr, class_idx, class_valid, class_score);
`else
  modport master (output start, buf_data, class_ready,
                  input busy, buf_rd, buf_adr, class_idx, class_valid);
  modport slave  (input start, buf_data, class_ready,
                  output busy, buf_rd, buf_adr, class_idx, class_valid);
`endif
endinterface

// File: rtl/dense_argmax_classifier.sv
// dense_argmax_classifier: scans OUT_COUNT signed scores and reports the argmax class.
// ARGMAX_SCORE_OUT_EN also registers the winning score onto class_score.
module dense_argmax_classifier #(
  parameter int OUT_COUNT     = 10,
  parameter int DATA_SIZE     = 32,
  parameter int OUT_ADR_WIDTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  dense_argmax_classifier_if.slave io
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [OUT_ADR_WIDTH-1:0] LAST_ADR = OUT_ADR_WIDTH'(OUT_COUNT - 1);
  state_t                      state, nextState;
  logic                        rd, rdValid, cmpDone;
  logic [OUT_ADR_WIDTH-1:0]    adr, rdIdx, bestIdx, classIdx;
  logic signed [DATA_SIZE-1:0] best;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nextState;
  always_comb begin
    nextState = state;
    nextState = (state == IDLE && io.start)       ? SCAN :
                (state == SCAN && cmpDone)        ? DONE :
                (state == DONE && io.class_ready) ? IDLE : state;
  end
  // rdValid/rdIdx trail the issued address by the one-cycle buffer read latency
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd       <= 1'b0;
      adr      <= '0;
      rdValid  <= 1'b0;
      rdIdx    <= '0;
      cmpDone  <= 1'b0;
      best     <= '0;
      bestIdx  <= '0;
      classIdx <= '0;
    end else begin
      rd      <= (state == IDLE) ? io.start : (state == SCAN && rd && adr != LAST_ADR);
      adr     <= (state == IDLE && io.start) ? '0 : (rd && adr != LAST_ADR) ? adr + 1'b1 : adr;
      rdValid <= rd;
      rdIdx   <= adr;
      cmpDone <= rdValid && rdIdx == LAST_ADR;
      if (rdValid && (rdIdx == '0 || $signed(io.buf_data) > best)) begin
        best    <= $signed(io.buf_data);
        bestIdx <= rdIdx;
      end
      if (state == SCAN && cmpDone) classIdx <= bestIdx;
    end
`ifdef ARGMAX_SCORE_OUT_EN
  logic [DATA_SIZE-1:0] classScore;
  always_ff @(posedge clk or negedge rst)
    if (!rst)                         classScore <= '0;
    else if (state == SCAN && cmpDone) classScore <= best;
  assign io.class_score = classScore;
`endif
  assign io.busy        = state == SCAN;
  assign io.buf_rd      = rd;
  assign io.buf_adr     = adr;
  assign io.class_idx   = classIdx;
  assign io.class_valid = state == DONE;
endmodule
